// File: rtl/vga_text_fetch_pkg.sv
// Shared definitions for the VGA text fetcher: FSM state encoding, ROM word
// layout constants and the character-word decode rule.
package vga_text_fetch_pkg;

    localparam int ADDR_W = 11;
    localparam int WORD_W = 32;
    localparam int CODE_W = 8;
    localparam int IDX_W  = 4;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_OUT  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Upper 24 bits all ones mark a character stored bit-inverted.
    localparam logic [23:0]       CIPHER_MASK = 24'hFFFFFF;
    localparam logic [WORD_W-1:0] TERMINATOR  = 32'h0;

    function automatic logic [CODE_W-1:0] decode_code(input logic [WORD_W-1:0] word);
        return (word[31:8] == CIPHER_MASK) ? ~word[7:0] : word[7:0];
    endfunction

endpackage

// File: rtl/vga_text_fetch_char_decode.sv
// Combinational decode of one ROM word into an ASCII code plus a flag that
// marks the end-of-run terminator word.
module char_decode
    import vga_text_fetch_pkg::*;
(
    input  logic [WORD_W-1:0] i_word,
    output logic [CODE_W-1:0] o_code,
    output logic              o_is_term
);

    assign o_code    = decode_code(i_word);
    assign o_is_term = (i_word == TERMINATOR);

endmodule

// File: rtl/vga_text_fetch.sv
// Walks consecutive character words in an external ROM, decodes each one and
// hands it to the text renderer over a valid/ready link, one run per start.
module vga_text_fetch
    import vga_text_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 11'h000,
    parameter int                NUM_CHARS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_data,
    output logic              char_valid,
    input  logic              char_ready,
    output logic [CODE_W-1:0] char_code,
    output logic [IDX_W-1:0]  char_idx,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHARS - 1);

    state_t            r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_count;
    logic [CODE_W-1:0] r_code;
    logic [IDX_W-1:0]  r_cidx;

    logic [CODE_W-1:0] w_code;
    logic              w_is_term;

    char_decode u_decode (
        .i_word    (mem_data),
        .o_code    (w_code),
        .o_is_term (w_is_term)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_count <= '0;
            r_code  <= '0;
            r_cidx  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_idx   <= '0;
                        r_count <= '0;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (w_is_term) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_code  <= w_code;
                        r_cidx  <= r_idx;
                        r_state <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    // Code and column stay frozen until the renderer takes them.
                    if (char_ready) begin
                        r_count <= r_count + CNT_W'(1);
                        if (r_idx == LAST_IDX) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_state <= ST_READ;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Word address wraps silently at the top of the 2 KiB ROM window.
    assign mem_addr   = BASE_ADDR + {5'd0, r_idx, 2'b00};
    assign char_valid = (r_state == ST_OUT);
    assign char_code  = r_code;
    assign char_idx   = r_cidx;
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign count      = r_count;

endmodule

// File: tb/tb_vga_text_fetch.sv
// Self-checking bench for vga_text_fetch: decode table, directed scenarios and
// randomized runs scored against a list-level model of the ROM walk.
module tb_vga_text_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] rom [0:511];

    logic        sel;
    logic        start, ready;

    logic        start_a, ready_a, valid_a, busy_a, done_a;
    logic [10:0] addr_a;
    logic [31:0] data_a;
    logic [7:0]  code_a;
    logic [3:0]  idx_a;
    logic [4:0]  count_a;

    logic        start_b, ready_b, valid_b, busy_b, done_b;
    logic [10:0] addr_b;
    logic [31:0] data_b;
    logic [7:0]  code_b;
    logic [3:0]  idx_b;
    logic [4:0]  count_b;

    assign data_a  = rom[addr_a[10:2]];
    assign data_b  = rom[addr_b[10:2]];
    assign start_a = sel ? 1'b0 : start;
    assign ready_a = sel ? 1'b0 : ready;
    assign start_b = sel ? start : 1'b0;
    assign ready_b = sel ? ready : 1'b0;

    vga_text_fetch #(.BASE_ADDR(11'h000), .NUM_CHARS(8)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .mem_addr(addr_a), .mem_data(data_a),
        .char_valid(valid_a), .char_ready(ready_a), .char_code(code_a), .char_idx(idx_a),
        .busy(busy_a), .done(done_a), .count(count_a)
    );

    vga_text_fetch #(.BASE_ADDR(11'h7FC), .NUM_CHARS(2)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .mem_addr(addr_b), .mem_data(data_b),
        .char_valid(valid_b), .char_ready(ready_b), .char_code(code_b), .char_idx(idx_b),
        .busy(busy_b), .done(done_b), .count(count_b)
    );

    logic        m_valid, m_busy, m_done;
    logic [10:0] m_addr;
    logic [7:0]  m_code;
    logic [3:0]  m_idx;
    logic [4:0]  m_count;

    assign m_valid = sel ? valid_b : valid_a;
    assign m_busy  = sel ? busy_b  : busy_a;
    assign m_done  = sel ? done_b  : done_a;
    assign m_addr  = sel ? addr_b  : addr_a;
    assign m_code  = sel ? code_b  : code_a;
    assign m_idx   = sel ? idx_b   : idx_a;
    assign m_count = sel ? count_b : count_a;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Reference: the run is the list of non-terminator words starting at the
    // base address, cut at the first terminator or after nmax words.
    logic [7:0] exp_code[$];
    int         exp_idx[$];
    logic [7:0] obs_code[$];

    function automatic void model(input logic [10:0] base, input int nmax);
        exp_code.delete();
        exp_idx.delete();
        for (int i = 0; i < nmax; i++) begin
            int          a;
            logic [31:0] w;
            a = (int'(base) + 4 * i) % 2048;
            w = rom[a / 4];
            if (w == 32'h0) break;
            exp_code.push_back((w[31:8] == 24'hFFFFFF) ? ~w[7:0] : w[7:0]);
            exp_idx.push_back(i);
        end
    endfunction

    function automatic logic [31:0] rand_word();
        int p;
        p = int'($urandom_range(0, 9));
        if (p == 0) return 32'h0;
        if (p <= 3) return {24'hFFFFFF, 8'($urandom)};
        return $urandom | 32'h1;
    endfunction

    // ready_mode: 0 = always ready, 1 = random, 2 = stalled for the first 5 valid cycles
    task automatic run(input string tag, input int ready_mode, input bit start_noise);
        logic [10:0] base;
        logic [10:0] ea;
        logic [7:0]  pcode, ec;
        logic [3:0]  pidx;
        int          nmax, n_exp, hs_n, cyc, lowleft, ei;
        bit          seen_done, pwait;
        base = sel ? 11'h7FC : 11'h000;
        nmax = sel ? 2 : 8;
        model(base, nmax);
        n_exp = exp_code.size();
        obs_code.delete();
        hs_n = 0; cyc = 0; lowleft = 5; seen_done = 0; pwait = 0; pcode = '0; pidx = '0;
        @(negedge clk);
        start = 1'b1;
        ready = (ready_mode == 0);
        while (!seen_done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            case (ready_mode)
                0: ready = 1'b1;
                1: ready = 1'($urandom_range(0, 1));
                default: begin
                    if (m_valid && lowleft > 0) begin
                        ready = 1'b0;
                        lowleft--;
                    end else begin
                        ready = 1'b1;
                    end
                end
            endcase
            check({tag, " busy"}, 32'(m_busy), 32'd1);
            if (!m_done) begin
                ea = base + 11'(4 * hs_n);
                check({tag, " mem_addr"}, 32'(m_addr), 32'(ea));
            end
            if (pwait) begin
                check({tag, " valid held"}, 32'(m_valid), 32'd1);
                check({tag, " code held"}, 32'(m_code), 32'(pcode));
                check({tag, " idx held"}, 32'(m_idx), 32'(pidx));
            end
            if (m_valid && ready) begin
                hs_n++;
                obs_code.push_back(m_code);
                if (exp_code.size() == 0) begin
                    check({tag, " extra char"}, 32'(hs_n), 32'(n_exp));
                end else begin
                    ec = exp_code.pop_front();
                    ei = exp_idx.pop_front();
                    check({tag, " char_code"}, 32'(m_code), 32'(ec));
                    check({tag, " char_idx"}, 32'(m_idx), 32'(ei));
                end
                pwait = 1'b0;
            end else begin
                pwait = m_valid;
                pcode = m_code;
                pidx  = m_idx;
            end
            if (m_done) begin
                seen_done = 1'b1;
                start = 1'b0;
                check({tag, " count"}, 32'(m_count), 32'(n_exp));
                check({tag, " delivered"}, 32'(hs_n), 32'(n_exp));
                if (ready_mode == 0)
                    check({tag, " done cycle"}, 32'(cyc),
                          32'((n_exp == nmax) ? 2 * n_exp + 1 : 2 * n_exp + 2));
            end
        end
        check({tag, " done seen"}, 32'(seen_done), 32'd1);
        @(negedge clk);
        start = 1'b0;
        ready = 1'b0;
        check({tag, " idle busy"}, 32'(m_busy), 32'd0);
        check({tag, " done pulse width"}, 32'(m_done), 32'd0);
        check({tag, " count held"}, 32'(m_count), 32'(n_exp));
    endtask

    typedef struct {
        logic [31:0] word;
        logic [7:0]  code;
        bit          term;
    } vec_t;

    vec_t       vt[8];
    logic [7:0] hola[4];

    initial begin
        vt[0] = '{32'h0000_0048, 8'h48, 1'b0};
        vt[1] = '{32'hFFFF_FFB0, 8'h4F, 1'b0};
        vt[2] = '{32'hFFFF_FFD9, 8'h26, 1'b0};
        vt[3] = '{32'h0000_0000, 8'h00, 1'b1};
        vt[4] = '{32'hFFFF_FFFF, 8'h00, 1'b0};
        vt[5] = '{32'hFFFE_FF30, 8'h30, 1'b0};
        vt[6] = '{32'h1234_5641, 8'h41, 1'b0};
        vt[7] = '{32'h0000_0100, 8'h00, 1'b0};
        hola  = '{8'h48, 8'h4F, 8'h4C, 8'h41};
        for (int i = 0; i < 512; i++) rom[i] = 32'h0;

        sel = 1'b0; start = 1'b0; ready = 1'b0; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset valid_a", 32'(valid_a), 32'd0);
        check("reset busy_a", 32'(busy_a), 32'd0);
        check("reset done_a", 32'(done_a), 32'd0);
        check("reset code_a", 32'(code_a), 32'd0);
        check("reset idx_a", 32'(idx_a), 32'd0);
        check("reset count_a", 32'(count_a), 32'd0);
        check("reset addr_a", 32'(addr_a), 32'h000);
        check("reset addr_b", 32'(addr_b), 32'h7FC);
        check("reset busy_b", 32'(busy_b), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-word decode table: one word then a terminator
        for (int i = 0; i < 8; i++) begin
            rom[0] = vt[i].word;
            rom[1] = 32'h0;
            start = 1'b1; ready = 1'b0;
            @(negedge clk);
            start = 1'b0;
            check("tbl read busy", 32'(m_busy), 32'd1);
            check("tbl read valid", 32'(m_valid), 32'd0);
            @(negedge clk);
            if (vt[i].term) begin
                check("tbl term done", 32'(m_done), 32'd1);
                check("tbl term count", 32'(m_count), 32'd0);
                check("tbl term valid", 32'(m_valid), 32'd0);
            end else begin
                check("tbl valid", 32'(m_valid), 32'd1);
                check("tbl code", 32'(m_code), 32'(vt[i].code));
                check("tbl idx", 32'(m_idx), 32'd0);
                ready = 1'b1;
                @(negedge clk);
                ready = 1'b0;
                @(negedge clk);
                check("tbl done", 32'(m_done), 32'd1);
                check("tbl count", 32'(m_count), 32'd1);
            end
            @(negedge clk);
            check("tbl idle", 32'(m_busy), 32'd0);
        end

        // Plain text run
        rom[0] = 32'd72; rom[1] = 32'd79; rom[2] = 32'd76; rom[3] = 32'd65; rom[4] = 32'd0;
        run("S1", 0, 1'b0);
        check("S1 n chars", 32'(obs_code.size()), 32'd4);
        for (int i = 0; i < 4 && i < obs_code.size(); i++)
            check("S1 HOLA", 32'(obs_code[i]), 32'(hola[i]));
        check("S1 final count", 32'(m_count), 32'd4);

        // Backpressure
        rom[0] = 32'hFFFF_FFB0; rom[1] = 32'h0000_0021; rom[2] = 32'h0;
        run("S3", 2, 1'b0);

        // Limit of 2 with wrap at the top of the ROM window
        sel = 1'b1;
        rom[511] = 32'h41; rom[0] = 32'h42; rom[1] = 32'h43;
        start = 1'b1; ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("S5 first addr", 32'(m_addr), 32'h7FC);
        @(negedge clk);
        check("S4 char0", 32'(m_code), 32'h41);
        @(negedge clk);
        check("S5 second addr", 32'(m_addr), 32'h000);
        @(negedge clk);
        check("S4 char1", 32'(m_code), 32'h42);
        check("S4 idx1", 32'(m_idx), 32'd1);
        @(negedge clk);
        check("S4 done", 32'(m_done), 32'd1);
        check("S4 count", 32'(m_count), 32'd2);
        ready = 1'b0;
        @(negedge clk);
        run("S4", 1, 1'b1);

        // Reset during OUT with start held while busy
        sel = 1'b0;
        rom[0] = 32'h5A; rom[1] = 32'h59; rom[2] = 32'h0;
        start = 1'b1; ready = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 10 && !m_valid; k++) @(negedge clk);
        check("S6 reached OUT", 32'(m_valid), 32'd1);
        repeat (3) @(negedge clk);
        check("S6 start ignored valid", 32'(m_valid), 32'd1);
        check("S6 start ignored code", 32'(m_code), 32'h5A);
        check("S6 start ignored idx", 32'(m_idx), 32'd0);
        start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("S6 rst valid", 32'(m_valid), 32'd0);
        check("S6 rst busy", 32'(m_busy), 32'd0);
        check("S6 rst done", 32'(m_done), 32'd0);
        check("S6 rst code", 32'(m_code), 32'd0);
        check("S6 rst count", 32'(m_count), 32'd0);
        check("S6 rst addr", 32'(m_addr), 32'h000);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("S6 no done after rst", 32'(m_done), 32'd0);
        end

        // Randomized runs
        for (int r = 0; r < 16; r++) begin
            sel = 1'b0;
            for (int j = 0; j < 12; j++) rom[j] = rand_word();
            run("RND_A", 1, 1'(r % 2));
        end
        for (int r = 0; r < 6; r++) begin
            sel = 1'b1;
            rom[511] = rand_word(); rom[0] = rand_word(); rom[1] = rand_word();
            run("RND_B", (r % 3 == 0) ? 0 : 1, 1'(r % 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
